// File: rtl/poseidon_input_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : poseidon_input_serializer
//  Description : Tuple FIFO feeding the Poseidon hash core. Each stored tuple
//                of three WIDTH-bit field elements is replayed as a 3-beat
//                valid/ready stream, with io_output_last on the third beat.
//                Optional packet counter enabled by POSEIDON_SER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module poseidon_input_serializer #(
  parameter int unsigned WIDTH = 255,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 10
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_tuple_valid,
  output logic                   s_tuple_ready,
  input  logic [3*WIDTH-1:0]     s_tuple_data,
  output logic                   io_output_valid,
  input  logic                   io_output_ready,
  output logic                   io_output_last,
  output logic [WIDTH-1:0]       io_output_payload,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef POSEIDON_SER_STATS_EN
  ,
  output logic [CNTW-1:0]        stat_packets
`endif
);

  localparam int unsigned      c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_depth   = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w:0] c_cnt_one = (c_ptr_w + 1)'(1);

  // Beat index within the tuple currently at the FIFO head.
  typedef enum logic [1:0] {
    BEAT0 = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } beat_e;

  logic [3*WIDTH-1:0] mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q;
  logic [c_ptr_w-1:0] rd_ptr_q;
  logic [c_ptr_w:0]   count_q;
  logic [c_ptr_w:0]   count_d;
  beat_e              beat_q;

  logic               w_valid;
  logic               w_ready;
  logic               w_push;
  logic               w_fire;
  logic               w_pop;
  logic [3*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_payload;

  // Illegal configurations (DEPTH not a power of two or below 2, empty
  // counter) leave this marker block in the elaborated hierarchy.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNTW == 0)) begin : g_bad_config
  end

  // Handshake decode. Ready is taken from the registered count only, so a
  // full FIFO refuses a push even while the head tuple is being popped.
  assign w_valid = (count_q != '0);
  assign w_ready = (count_q < c_depth);
  assign w_push  = s_tuple_valid & w_ready;
  assign w_fire  = w_valid & io_output_ready;
  assign w_pop   = w_fire & (beat_q == BEAT2);
  assign w_head  = mem_q[rd_ptr_q];

  // Next occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  // Element select for the current beat; zero whenever nothing is offered.
  always_comb begin
    w_payload = '0;
    if (w_valid) begin
      unique case (beat_q)
        BEAT0:   w_payload = w_head[0       +: WIDTH];
        BEAT1:   w_payload = w_head[WIDTH   +: WIDTH];
        default: w_payload = w_head[2*WIDTH +: WIDTH];
      endcase
    end
  end

  // Tuple storage; contents are only observed once written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= s_tuple_data;
    end
  end

  // Pointers, occupancy and the beat FSM; the beat only moves on a fire and
  // returns to BEAT0 when the head tuple is popped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= BEAT0;
    end else begin
      count_q <= count_d;
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_fire) begin
        unique case (beat_q)
          BEAT0: beat_q <= BEAT1;
          BEAT1: beat_q <= BEAT2;
          default: begin
            beat_q   <= BEAT0;
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        endcase
      end
    end
  end

  assign s_tuple_ready     = w_ready;
  assign io_output_valid   = w_valid;
  assign io_output_last    = w_valid & (beat_q == BEAT2);
  assign io_output_payload = w_payload;
  assign occupancy         = count_q;

`ifdef POSEIDON_SER_STATS_EN
  logic [CNTW-1:0] stat_q;

  // Completed-packet counter, wrapping naturally at 2^CNTW.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_q <= '0;
    end else if (w_pop) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign stat_packets = stat_q;
`endif

endmodule
`default_nettype wire
